fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fq_ring_buffer.sv | 53 +++++
 rtl/fetch_queue.sv | 108 ++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: the NOP word shown when
// the queue is empty, the default boot address, the request FSM states and the
// {pc, inst} entry layout stored in the ring buffer.
package fetch_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetchState_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetchEntry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's memory-side and pipeline-side signals.
// The master modport is the fetch queue itself; the slave modport is the
// environment (instruction memory plus IF stage).
interface fetch_queue_if;

  logic        o_imemReq;
  logic [31:0] o_imemAddr;
  logic        i_imemAck;
  logic [31:0] i_imemData;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirectPC;

  modport master (
    output o_imemReq, o_imemAddr, o_valid, o_inst, o_pc,
    input  i_imemAck, i_imemData, i_stall, i_redirect, i_redirectPC
  );

  modport slave (
    input  o_imemReq, o_imemAddr, o_valid, o_inst, o_pc,
    output i_imemAck, i_imemData, i_stall, i_redirect, i_redirectPC
  );

endinterface

// File: rtl/fq_ring_buffer.sv
// Ring buffer of DEPTH fetch entries with push, pop and a clear that wins over
// both. DEPTH must be a power of two so the pointers wrap on their own.
module fq_ring_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  fetchEntry_t            pushEntry_i,
  input  logic                   pop_i,
  input  logic                   clear_i,
  output logic [$clog2(DEPTH):0] count_o,
  output fetchEntry_t            head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  fetchEntry_t     mem_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [PW:0]     count_q;

  // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PTR_ONE;
      if (pop_i)  head_q <= head_q + PTR_ONE;
      if (push_i && !pop_i)      count_q <= count_q + CNT_ONE;
      else if (!push_i && pop_i) count_q <= count_q - CNT_ONE;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[tail_q] <= pushEntry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues one outstanding word fetch at a time into a
// slot reserved in the ring buffer, and presents the oldest word to the IF
// stage. Control-flow redirects flush the queue and discard any response
// still in flight.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN (empty-queue bypass of the
// returning word straight to the IF stage in the ack cycle).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic           clk,
  input  logic           reset_x,
  fetch_queue_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  fetchState_e   state_q;
  logic [31:0]   fetchPc_q;
  logic [CW-1:0] count;
  logic [CW-1:0] countNext;
  fetchEntry_t   headEntry;
  fetchEntry_t   pushEntry;
  logic [31:0]   redirectTarget;
  logic          ackWait;
  logic          bypass;
  logic          outValid;
  logic          push;
  logic          bufPop;
  logic          empty;

  assign empty          = (count == '0);
  assign redirectTarget = bus.i_redirectPC & 32'hFFFF_FFFC;
  assign ackWait        = (state_q == WAIT) && bus.i_imemAck && !bus.i_redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = ackWait && empty;
`else
  assign bypass = 1'b0;
`endif

  assign outValid  = (!empty || bypass) && !bus.i_redirect;
  assign bufPop    = outValid && !bus.i_stall && !empty;
  assign push      = ackWait && !(bypass && !bus.i_stall);
  assign pushEntry = '{pc: fetchPc_q, inst: bus.i_imemData};

  // Occupancy after this cycle's push/pop, used to decide whether the next slot is free.
  always_comb begin
    countNext = count;
    if (push && !bufPop)      countNext = count + CNT_ONE;
    else if (!push && bufPop) countNext = count - CNT_ONE;
  end

  fq_ring_buffer #(.DEPTH(DEPTH)) u_ring (
    .clk         (clk),
    .rst_n       (reset_x),
    .push_i      (push),
    .pushEntry_i (pushEntry),
    .pop_i       (bufPop),
    .clear_i     (bus.i_redirect),
    .count_o     (count),
    .head_o      (headEntry)
  );

  // Request FSM and fetch address: a request only starts when a slot is reserved.
  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_redirect) begin
            state_q   <= WAIT;
            fetchPc_q <= redirectTarget;
          end else if (count < DEPTH_C) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (bus.i_redirect) begin
            fetchPc_q <= redirectTarget;
            state_q   <= bus.i_imemAck ? WAIT : DROP;
          end else if (bus.i_imemAck) begin
            fetchPc_q <= fetchPc_q + 32'd4;
            state_q   <= (countNext < DEPTH_C) ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (bus.i_redirect) fetchPc_q <= redirectTarget;
          if (bus.i_imemAck)  state_q   <= WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_imemReq  = (state_q == WAIT);
  assign bus.o_imemAddr = fetchPc_q;
  assign bus.o_valid    = outValid;
  assign bus.o_inst     = !empty ? headEntry.inst : (bypass ? bus.i_imemData : NOP_INST);
  assign bus.o_pc       = !empty ? headEntry.pc   : (bypass ? fetchPc_q      : 32'h0);

endmodule
